// File: rtl/lap_pkg.sv
// Shared types for the lap recorder: FSM states, default widths and index/count types.
package lap_pkg;

  localparam int LAP_DEPTH  = 8;
  localparam int LAP_TIME_W = 24;
  localparam int LAP_IDX_W  = $clog2(LAP_DEPTH);
  localparam int LAP_CNT_W  = LAP_IDX_W + 1;

  typedef logic [LAP_IDX_W-1:0]  lap_idx_t;
  typedef logic [LAP_CNT_W-1:0]  lap_cnt_t;
  typedef logic [LAP_TIME_W-1:0] lap_time_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2,
    HOLD  = 2'd3
  } lap_state_t;

endpackage

// File: rtl/lap_ram.sv
// Lap storage: simple dual-port RAM, one write port and a registered read port.
// A read of the address being written in the same cycle returns the new data.
module lap_ram #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 24,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A lap written on the same edge it is first fetched must show the new value.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      if (wr_en && (wr_addr == rd_addr)) begin
        rd_data_reg <= wr_data;
      end else begin
        rd_data_reg <= mem[rd_addr];
      end
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/lap_record_reader.sv
// Stopwatch lap recorder: captures laps on rec_stb and replays them oldest-first on print_stb.
// Define LAP_AUTO_PLAY_EN to replace manual stepping with timed auto-play (HOLD_CYC cycles per entry).
module lap_record_reader
  import lap_pkg::*;
#(
  parameter int DEPTH    = LAP_DEPTH,
  parameter int TIME_W   = LAP_TIME_W,
  parameter int HOLD_CYC = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rec_stb,
  input  logic [TIME_W-1:0]        rec_time,
  input  logic                     clr,
  input  logic                     print_stb,
  output logic                     disp_valid,
  output logic [TIME_W-1:0]        disp_time,
  output logic [$clog2(DEPTH)-1:0] disp_idx,
  output logic [$clog2(DEPTH):0]   lap_cnt,
  output logic                     full,
  output logic                     playing
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  lap_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  lap_cnt_reg, lap_cnt_next;
  logic [IDX_W-1:0]  rd_idx_reg, rd_idx_next;
  logic              disp_valid_reg, disp_valid_next;
  logic [TIME_W-1:0] disp_time_reg;
  logic [IDX_W-1:0]  disp_idx_reg;
  logic              rec_ok;
  logic              rd_en;
  logic              latch_disp;
  logic              has_next;
  logic [TIME_W-1:0] rd_data;

  assign full         = (lap_cnt_reg == CNT_W'(DEPTH));
  assign rec_ok       = rec_stb && !full && !clr;
  assign lap_cnt_next = clr ? '0 : lap_cnt_reg + CNT_W'(rec_ok);
  // End-of-list test uses the count including a lap accepted this very cycle.
  assign has_next     = (CNT_W'(rd_idx_reg) + CNT_W'(1)) < lap_cnt_next;

  lap_ram #(
    .DEPTH (DEPTH),
    .WIDTH (TIME_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (rec_ok),
    .wr_addr (wr_ptr_reg),
    .wr_data (rec_time),
    .rd_en   (rd_en),
    .rd_addr (rd_idx_next),
    .rd_data (rd_data)
  );

`ifdef LAP_AUTO_PLAY_EN
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              hold_done;

  // The next entry's fetch cycle still shows the old value, so advancing expires one cycle early.
  assign hold_done = has_next ? (hold_cnt_reg >= HOLD_W'(HOLD_CYC - 2))
                              : (hold_cnt_reg >= HOLD_W'(HOLD_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_reg <= '0;
    end else if (state_reg == HOLD && state_next == HOLD) begin
      hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
    end else begin
      hold_cnt_reg <= '0;
    end
  end
`endif

  always_comb begin
    state_next      = state_reg;
    rd_idx_next     = rd_idx_reg;
    rd_en           = 1'b0;
    latch_disp      = 1'b0;
    disp_valid_next = disp_valid_reg;
    if (clr) begin
      state_next      = IDLE;
      disp_valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (print_stb && lap_cnt_reg != '0) begin
            rd_idx_next = '0;
            rd_en       = 1'b1;
            state_next  = FETCH;
          end
        end
        FETCH: begin
          latch_disp      = 1'b1;
          disp_valid_next = 1'b1;
`ifdef LAP_AUTO_PLAY_EN
          state_next      = HOLD;
`else
          state_next      = SHOW;
`endif
        end
`ifdef LAP_AUTO_PLAY_EN
        HOLD: begin
          if (print_stb) begin
            disp_valid_next = 1'b0;
            state_next      = IDLE;
          end else if (hold_done) begin
            if (has_next) begin
              rd_idx_next = rd_idx_reg + IDX_W'(1);
              rd_en       = 1'b1;
              state_next  = FETCH;
            end else begin
              disp_valid_next = 1'b0;
              state_next      = IDLE;
            end
          end
        end
`else
        SHOW: begin
          if (print_stb) begin
            if (has_next) begin
              rd_idx_next = rd_idx_reg + IDX_W'(1);
              rd_en       = 1'b1;
              state_next  = FETCH;
            end else begin
              disp_valid_next = 1'b0;
              state_next      = IDLE;
            end
          end
        end
`endif
        default: begin
          state_next      = IDLE;
          disp_valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      lap_cnt_reg    <= '0;
      rd_idx_reg     <= '0;
      disp_valid_reg <= 1'b0;
      disp_time_reg  <= '0;
      disp_idx_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      lap_cnt_reg    <= lap_cnt_next;
      rd_idx_reg     <= rd_idx_next;
      disp_valid_reg <= disp_valid_next;
      if (clr) begin
        wr_ptr_reg <= '0;
      end else if (rec_ok) begin
        wr_ptr_reg <= wr_ptr_reg + IDX_W'(1);
      end
      if (latch_disp) begin
        disp_time_reg <= rd_data;
        disp_idx_reg  <= rd_idx_reg;
      end
    end
  end

  assign disp_valid = disp_valid_reg;
  assign disp_time  = disp_time_reg;
  assign disp_idx   = disp_idx_reg;
  assign lap_cnt    = lap_cnt_reg;
  assign playing    = (state_reg != IDLE);

endmodule

// File: tb/tb_lap_record_reader.sv
// Directed bench for lap_record_reader: recording, stepping, full, same-cycle and clear cases.
// Auto-play checks run when LAP_AUTO_PLAY_EN is defined, manual stepping checks otherwise.
module tb_lap_record_reader;

  localparam int DEPTH  = 8;
  localparam int TIME_W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              rec_stb;
  logic [TIME_W-1:0] rec_time;
  logic              clr;
  logic              print_stb;
  logic              disp_valid;
  logic [TIME_W-1:0] disp_time;
  logic [2:0]        disp_idx;
  logic [3:0]        lap_cnt;
  logic              full;
  logic              playing;

  int n_cmp = 0;
  int n_err = 0;

  lap_record_reader #(
    .DEPTH    (DEPTH),
    .TIME_W   (TIME_W),
    .HOLD_CYC (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rec_stb    (rec_stb),
    .rec_time   (rec_time),
    .clr        (clr),
    .print_stb  (print_stb),
    .disp_valid (disp_valid),
    .disp_time  (disp_time),
    .disp_idx   (disp_idx),
    .lap_cnt    (lap_cnt),
    .full       (full),
    .playing    (playing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic record(input logic [TIME_W-1:0] val);
    rec_stb  = 1'b1;
    rec_time = val;
    tick();
    rec_stb  = 1'b0;
    $display("record 0x%06h -> lap_cnt=%0d full=%0b", val, lap_cnt, full);
  endtask

  task automatic print_pulse();
    print_stb = 1'b1;
    tick();
    print_stb = 1'b0;
    $display("print -> playing=%0b valid=%0b", playing, disp_valid);
  endtask

  task automatic clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    $display("clear -> lap_cnt=%0d", lap_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rec_stb = 1'b0; rec_time = '0; clr = 1'b0; print_stb = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid",   32'(disp_valid), 32'd0);
    check("rst_time",    32'(disp_time),  32'd0);
    check("rst_idx",     32'(disp_idx),   32'd0);
    check("rst_cnt",     32'(lap_cnt),    32'd0);
    check("rst_full",    32'(full),       32'd0);
    check("rst_playing", 32'(playing),    32'd0);

    // Print with no laps stays idle
    print_pulse();
    tick();
    check("empty_playing", 32'(playing),    32'd0);
    check("empty_valid",   32'(disp_valid), 32'd0);
    check("empty_cnt",     32'(lap_cnt),    32'd0);

`ifndef LAP_AUTO_PLAY_EN
    // Three laps stepped manually, two-cycle latency
    record(24'h000123);
    record(24'h000456);
    record(24'h001000);
    check("t2_cnt", 32'(lap_cnt), 32'd3);
    print_pulse();
    check("t2_lat_valid", 32'(disp_valid), 32'd0);
    check("t2_lat_play",  32'(playing),    32'd1);
    tick();
    check("t2_v0",    32'(disp_valid), 32'd1);
    check("t2_time0", 32'(disp_time),  32'h000123);
    check("t2_idx0",  32'(disp_idx),   32'd0);
    print_pulse();
    check("t2_hold_valid", 32'(disp_valid), 32'd1);
    check("t2_hold_time",  32'(disp_time),  32'h000123);
    tick();
    check("t2_time1", 32'(disp_time), 32'h000456);
    check("t2_idx1",  32'(disp_idx),  32'd1);
    print_pulse();
    tick();
    check("t2_time2", 32'(disp_time), 32'h001000);
    check("t2_idx2",  32'(disp_idx),  32'd2);
    print_pulse();
    check("t2_end_valid",   32'(disp_valid), 32'd0);
    check("t2_end_playing", 32'(playing),    32'd0);
    check("t2_end_time",    32'(disp_time),  32'h001000);
    check("t2_end_idx",     32'(disp_idx),   32'd2);

    // Nine records into eight slots; the ninth is dropped
    clear();
    check("t3_clr_cnt", 32'(lap_cnt), 32'd0);
    for (int i = 0; i < 9; i++) record(TIME_W'(32'h100 + i));
    check("t3_cnt",  32'(lap_cnt), 32'd8);
    check("t3_full", 32'(full),    32'd1);
    for (int i = 0; i < 8; i++) begin
      print_pulse();
      tick();
      check("t3_time", 32'(disp_time), 32'h100 + 32'(i));
      check("t3_idx",  32'(disp_idx),  32'(i));
    end
    print_pulse();
    check("t3_end_valid", 32'(disp_valid), 32'd0);
    check("t3_end_play",  32'(playing),    32'd0);

    // Record and print in the same cycle on the last lap
    clear();
    record(24'h000777);
    print_pulse();
    tick();
    check("t4_time0", 32'(disp_time), 32'h000777);
    rec_stb = 1'b1; rec_time = 24'h000888; print_stb = 1'b1;
    tick();
    rec_stb = 1'b0; print_stb = 1'b0;
    $display("record+print -> lap_cnt=%0d playing=%0b", lap_cnt, playing);
    check("t4_cnt",     32'(lap_cnt),    32'd2);
    check("t4_playing", 32'(playing),    32'd1);
    tick();
    check("t4_valid", 32'(disp_valid), 32'd1);
    check("t4_idx1",  32'(disp_idx),   32'd1);
    check("t4_time1", 32'(disp_time),  32'h000888);
`else
    // Auto-play: two laps, each shown for four cycles
    record(24'h000011);
    record(24'h000022);
    print_pulse();
    tick();
    for (int e = 0; e < 2; e++) begin
      for (int k = 0; k < 4; k++) begin
        check("t6_valid", 32'(disp_valid), 32'd1);
        check("t6_idx",   32'(disp_idx),   32'(e));
        check("t6_time",  32'(disp_time),  (e == 0) ? 32'h11 : 32'h22);
        tick();
      end
    end
    check("t6_end_valid", 32'(disp_valid), 32'd0);
    check("t6_end_play",  32'(playing),    32'd0);

    // Print during HOLD aborts
    print_pulse();
    tick();
    check("t6_ab_valid", 32'(disp_valid), 32'd1);
    tick();
    print_pulse();
    check("t6_ab_end_valid", 32'(disp_valid), 32'd0);
    check("t6_ab_end_play",  32'(playing),    32'd0);

    // Restart playback so the clear below lands mid-playback
    print_pulse();
    tick();
`endif

    // Clear beats a same-cycle record mid-playback
    check("t5_pre_play", 32'(playing), 32'd1);
    clr = 1'b1; rec_stb = 1'b1; rec_time = 24'h000999;
    tick();
    clr = 1'b0; rec_stb = 1'b0;
    $display("clear+record -> lap_cnt=%0d playing=%0b", lap_cnt, playing);
    check("t5_cnt",     32'(lap_cnt),    32'd0);
    check("t5_valid",   32'(disp_valid), 32'd0);
    check("t5_playing", 32'(playing),    32'd0);
    check("t5_full",    32'(full),       32'd0);
    print_pulse();
    tick();
    check("t5_idle", 32'(playing), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
